// File: rtl/mem_ctrl_arb_if.sv
// Bus bundle between the core-side ports, the arbiter and the byte-wide RAM.
interface mem_ctrl_arb_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_BYTES = 4
);
    localparam int unsigned DW = 8 * DATA_BYTES;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_abort;
    logic              if_done;
    logic [DW-1:0]     if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [1:0]        dm_size;
    logic              dm_signed;
    logic [ADDR_W-1:0] dm_addr;
    logic [DW-1:0]     dm_wdata;
    logic              dm_done;
    logic [DW-1:0]     dm_rdata;

    logic              busy;
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_dout;
    logic              mem_wr;
    logic [7:0]        mem_din;

    // Controller side
    modport slave (
        input  if_req, if_addr, if_abort, dm_req, dm_we, dm_size, dm_signed, dm_addr, dm_wdata,
        input  mem_din,
        output if_done, if_rdata, dm_done, dm_rdata, busy, mem_a, mem_dout, mem_wr
    );

    // Core / RAM side
    modport master (
        output if_req, if_addr, if_abort, dm_req, dm_we, dm_size, dm_signed, dm_addr, dm_wdata,
        output mem_din,
        input  if_done, if_rdata, dm_done, dm_rdata, busy, mem_a, mem_dout, mem_wr
    );
endinterface

// File: rtl/mem_ctrl_arb.sv
// Byte-serial memory controller: arbitrates IF reads and DM loads/stores onto one
// byte-wide RAM bus, with sized accesses, load extension and IF abort.
module mem_ctrl_arb #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned RD_LAT     = 1
) (
    input logic           clk,
    input logic           rst,
    mem_ctrl_arb_if.slave bus
);
    localparam int unsigned DW = 8 * DATA_BYTES;

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_t;

    state_t            state_q;
    logic              is_dm_q;
    logic              sgn_q;
    logic [3:0]        n_q;
    logic [3:0]        cnt_q;   // edges elapsed since the accept edge
    logic [ADDR_W-1:0] base_q;
    logic [DW-1:0]     wdata_q;
    logic [DW-1:0]     rbuf_q;

    logic [3:0]        dm_n;
    logic [3:0]        rd_last;
    logic [3:0]        rd_idx;
    logic [7:0]        wr_byte;
    logic              fill_bit;
    logic [DW-1:0]     ext_data;

    // Access size in bytes, clamped to the bus width
    always_comb begin
        dm_n = 4'd1 << bus.dm_size;
        if (dm_n > 4'(DATA_BYTES)) dm_n = 4'(DATA_BYTES);
    end

    // Read timing: byte k sampled when cnt = k+1+RD_LAT, done one edge after the last sample
    always_comb begin
        rd_last = n_q + 4'(RD_LAT) + 4'd1;
        rd_idx  = cnt_q - 4'(RD_LAT) - 4'd1;
        wr_byte = 8'(wdata_q >> {cnt_q, 3'b000});
    end

    // Load extension from the top valid byte
    always_comb begin
        fill_bit = 1'b0;
        ext_data = rbuf_q;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (4'(i) == n_q - 4'd1) fill_bit = sgn_q & rbuf_q[8*i+7];
        end
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (4'(i) >= n_q) ext_data[8*i +: 8] = {8{fill_bit}};
        end
    end

    // Controller FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            is_dm_q      <= 1'b0;
            sgn_q        <= 1'b0;
            n_q          <= '0;
            cnt_q        <= '0;
            base_q       <= '0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            bus.if_done  <= 1'b0;
            bus.if_rdata <= '0;
            bus.dm_done  <= 1'b0;
            bus.dm_rdata <= '0;
            bus.busy     <= 1'b0;
            bus.mem_a    <= '0;
            bus.mem_dout <= '0;
            bus.mem_wr   <= 1'b0;
        end else begin
            bus.if_done <= 1'b0;
            bus.dm_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    // A port still showing its done pulse is not re-accepted
                    if (bus.dm_req && !bus.dm_done) begin
                        is_dm_q   <= 1'b1;
                        sgn_q     <= bus.dm_signed;
                        n_q       <= dm_n;
                        cnt_q     <= 4'd1;
                        base_q    <= bus.dm_addr;
                        wdata_q   <= bus.dm_wdata;
                        rbuf_q    <= '0;
                        bus.busy  <= 1'b1;
                        bus.mem_a <= bus.dm_addr;
                        if (bus.dm_we) begin
                            state_q      <= StWr;
                            bus.mem_wr   <= 1'b1;
                            bus.mem_dout <= bus.dm_wdata[7:0];
                        end else begin
                            state_q <= StRd;
                        end
                    end else if (bus.if_req && !bus.if_abort && !bus.if_done) begin
                        is_dm_q   <= 1'b0;
                        sgn_q     <= 1'b0;
                        n_q       <= 4'(DATA_BYTES);
                        cnt_q     <= 4'd1;
                        base_q    <= bus.if_addr;
                        rbuf_q    <= '0;
                        bus.busy  <= 1'b1;
                        bus.mem_a <= bus.if_addr;
                        state_q   <= StRd;
                    end
                end
                StWr: begin
                    if (cnt_q == n_q) begin
                        bus.mem_wr  <= 1'b0;
                        bus.dm_done <= 1'b1;
                        bus.busy    <= 1'b0;
                        state_q     <= StIdle;
                    end else begin
                        bus.mem_a    <= base_q + ADDR_W'(cnt_q);
                        bus.mem_dout <= wr_byte;
                        cnt_q        <= cnt_q + 4'd1;
                    end
                end
                StRd: begin
                    if (!is_dm_q && bus.if_abort) begin
                        // Bytes still in the RAM pipeline are dropped with the access
                        bus.busy <= 1'b0;
                        state_q  <= StIdle;
                    end else if (cnt_q == rd_last) begin
                        bus.busy <= 1'b0;
                        state_q  <= StIdle;
                        if (is_dm_q) begin
                            bus.dm_done  <= 1'b1;
                            bus.dm_rdata <= ext_data;
                        end else begin
                            bus.if_done  <= 1'b1;
                            bus.if_rdata <= rbuf_q;
                        end
                    end else begin
                        if (cnt_q < n_q) bus.mem_a <= base_q + ADDR_W'(cnt_q);
                        if (cnt_q >= 4'(RD_LAT + 1)) begin
                            for (int i = 0; i < DATA_BYTES; i++) begin
                                if (4'(i) == rd_idx) rbuf_q[8*i +: 8] <= bus.mem_din;
                            end
                        end
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Bench for mem_ctrl_arb: RAM models, DM/IF scoreboards, vector table and corner sequences.
module tb_mem_ctrl_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_ctrl_arb_if #(.ADDR_W(32), .DATA_BYTES(4)) bus_a ();
    mem_ctrl_arb_if #(.ADDR_W(32), .DATA_BYTES(8)) bus_b ();

    mem_ctrl_arb #(.ADDR_W(32), .DATA_BYTES(4), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    mem_ctrl_arb #(.ADDR_W(32), .DATA_BYTES(8), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    // RAM A: latency 1, writable; RAM B: latency 3, read-only
    logic [7:0]  ram_a [0:1023] = '{default: 8'h00};
    logic [7:0]  ram_b [0:1023];
    logic [31:0] pipe_a = '0;
    logic [31:0] pipe_b [0:2] = '{default: 32'h0};

    always @(posedge clk) begin
        pipe_a <= bus_a.mem_a;
        if (bus_a.mem_wr) ram_a[bus_a.mem_a[9:0]] <= bus_a.mem_dout;
        pipe_b[0] <= bus_b.mem_a;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign bus_a.mem_din = ram_a[pipe_a[9:0]];
    assign bus_b.mem_din = ram_b[pipe_b[2][9:0]];

    typedef struct packed {
        logic        is_load;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    exp_t        dm_q[$];
    logic [31:0] if_q[$];
    int errors = 0;
    int checks = 0;
    int if_done_cnt = 0;
    int wr_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for port A
    always @(negedge clk) begin
        exp_t e;
        if (bus_a.mem_wr) wr_cycles++;
        if (bus_a.dm_done && bus_a.if_done) begin
            checks++;
            errors++;
            $display("FAIL both_done: got 1 expected 0");
        end
        if (bus_a.dm_done) begin
            if (dm_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dm_unexpected_done: got 1 expected 0");
            end else begin
                e = dm_q.pop_front();
                if (e.is_load) chk("dm_rdata", 64'(bus_a.dm_rdata), 64'(e.data));
            end
        end
        if (bus_a.if_done) begin
            if_done_cnt++;
            if (if_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL if_unexpected_done: got 1 expected 0");
            end else begin
                chk("if_rdata", 64'(bus_a.if_rdata), 64'(if_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dm_access(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp, input int lat, input string name);
        int   n = 0;
        exp_t e;
        e.is_load = !we;
        e.data    = exp;
        dm_q.push_back(e);
        bus_a.dm_we     = we;
        bus_a.dm_size   = size;
        bus_a.dm_signed = sgn;
        bus_a.dm_addr   = addr;
        bus_a.dm_wdata  = wdata;
        bus_a.dm_req    = 1'b1;
        do begin tick(); n++; end while (!bus_a.dm_done && n < 40);
        chk({name, "_lat"}, 64'(n - 1), 64'(lat));
        bus_a.dm_req = 1'b0;
        tick();
    endtask

    task automatic if_access(input logic [31:0] addr, input logic [31:0] exp, input int lat,
                             input string name);
        int n = 0;
        if_q.push_back(exp);
        bus_a.if_addr = addr;
        bus_a.if_req  = 1'b1;
        do begin tick(); n++; end while (!bus_a.if_done && n < 40);
        chk({name, "_lat"}, 64'(n - 1), 64'(lat));
        bus_a.if_req = 1'b0;
        tick();
    endtask

    vec_t vecs[13];

    initial begin
        int n;
        vecs[0]  = '{1'b1, 2'd1, 1'b0, 32'h201, 32'h0000_8534, 32'h0, 2, "st_half_201"};
        vecs[1]  = '{1'b1, 2'd2, 1'b0, 32'h010, 32'h0000_0013, 32'h0, 4, "st_word_010"};
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h020, 32'hDDCC_BBAA, 32'h0, 4, "st_word_020"};
        vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h300, 32'h1234_5655, 32'h0, 1, "st_byte_300"};
        vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h201, 32'h0, 32'hFFFF_8534, 4, "ld_half_s"};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h201, 32'h0, 32'h0000_8534, 4, "ld_half_u"};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 6, "ld_word"};
        vecs[7]  = '{1'b0, 2'd0, 1'b1, 32'h100, 32'h0, 32'hFFFF_FFEF, 3, "ld_byte_s"};
        vecs[8]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h0000_00DE, 3, "ld_byte_u"};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0000_0055, 6, "ld_word_300"};
        vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 6, "ld_clamp"};
        vecs[11] = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'hFFFF_DEAD, 4, "ld_half_102"};
        vecs[12] = '{1'b0, 2'd0, 1'b1, 32'h202, 32'h0, 32'hFFFF_FF85, 3, "ld_byte_202"};

        for (int i = 0; i < 1024; i++) ram_b[i] = 8'h00;
        ram_b[10'h3FC] = 8'h01; ram_b[10'h3FD] = 8'h82; ram_b[10'h3FE] = 8'h03;
        ram_b[10'h3FF] = 8'h04; ram_b[0] = 8'h05; ram_b[1] = 8'h06; ram_b[2] = 8'h07;
        ram_b[3] = 8'h08;

        {bus_a.if_req, bus_a.if_abort, bus_a.dm_req, bus_a.dm_we, bus_a.dm_signed} = '0;
        bus_a.if_addr = '0; bus_a.dm_size = '0; bus_a.dm_addr = '0; bus_a.dm_wdata = '0;
        {bus_b.if_req, bus_b.if_abort, bus_b.dm_req, bus_b.dm_we, bus_b.dm_signed} = '0;
        bus_b.if_addr = '0; bus_b.dm_size = '0; bus_b.dm_addr = '0; bus_b.dm_wdata = '0;

        #1 rst = 1'b0;
        tick(); tick();
        chk("rst_busy", 64'(bus_a.busy), 64'd0);
        chk("rst_mem_wr", 64'(bus_a.mem_wr), 64'd0);
        chk("rst_mem_a", 64'(bus_a.mem_a), 64'd0);
        chk("rst_dm_rdata", 64'(bus_a.dm_rdata), 64'd0);
        chk("rst_if_done", 64'(bus_a.if_done), 64'd0);
        @(negedge clk) rst = 1'b1;
        tick();

        // Word store: four write strobes, bytes little-endian
        wr_cycles = 0;
        dm_access(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 4, "st_word_100");
        chk("st_wr_cycles", 64'(wr_cycles), 64'd4);
        chk("st_mem_a_hold", 64'(bus_a.mem_a), 64'h103);
        chk("st_mem_wr_low", 64'(bus_a.mem_wr), 64'd0);
        chk("ram_100", 64'({ram_a[10'h103], ram_a[10'h102], ram_a[10'h101], ram_a[10'h100]}),
            64'hDEAD_BEEF);

        for (int i = 0; i < 13; i++) begin
            dm_access(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp, vecs[i].lat, vecs[i].name);
        end

        // Simultaneous requests: DM first, IF accepted the edge after DM done
        if_q.push_back(32'h0000_0013);
        dm_q.push_back(exp_t'{1'b1, 32'hDEAD_BEEF});
        bus_a.dm_we = 1'b0; bus_a.dm_size = 2'd2; bus_a.dm_signed = 1'b0;
        bus_a.dm_addr = 32'h100; bus_a.if_addr = 32'h10;
        bus_a.dm_req = 1'b1; bus_a.if_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus_a.dm_done && n < 40);
        chk("prio_dm_lat", 64'(n - 1), 64'd6);
        chk("prio_no_if_done", 64'(bus_a.if_done), 64'd0);
        bus_a.dm_req = 1'b0;
        tick();
        chk("prio_if_busy", 64'(bus_a.busy), 64'd1);
        chk("prio_if_addr", 64'(bus_a.mem_a), 64'h10);
        n = 0;
        do begin tick(); n++; end while (!bus_a.if_done && n < 40);
        chk("prio_if_lat", 64'(n), 64'd6);
        bus_a.if_req = 1'b0;
        tick();

        // Abort on the second cycle of an IF read
        n = if_done_cnt;
        bus_a.if_addr = 32'h20; bus_a.if_req = 1'b1;
        tick(); tick();
        bus_a.if_abort = 1'b1; bus_a.if_req = 1'b0;
        tick();
        chk("abort_busy", 64'(bus_a.busy), 64'd0);
        bus_a.if_abort = 1'b0;
        dm_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 6, "after_abort");
        tick(); tick(); tick();
        chk("abort_no_if_done", 64'(if_done_cnt), 64'(n));

        // Abort together with a request in IDLE blocks that cycle only
        bus_a.if_addr = 32'h10; bus_a.if_req = 1'b1; bus_a.if_abort = 1'b1;
        tick();
        chk("abort_idle_busy", 64'(bus_a.busy), 64'd0);
        bus_a.if_req = 1'b0; bus_a.if_abort = 1'b0;
        if_access(32'h10, 32'h0000_0013, 6, "if_fetch");

        // Asynchronous reset in the middle of a read
        bus_a.dm_we = 1'b0; bus_a.dm_size = 2'd2; bus_a.dm_addr = 32'h100;
        bus_a.dm_req = 1'b1;
        tick(); tick();
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus_a.busy), 64'd0);
        chk("midrst_mem_a", 64'(bus_a.mem_a), 64'd0);
        chk("midrst_rdata", 64'(bus_a.dm_rdata), 64'd0);
        bus_a.dm_req = 1'b0;
        @(negedge clk) rst = 1'b1;
        tick();
        dm_access(1'b0, 2'd1, 1'b1, 32'h201, 32'h0, 32'hFFFF_8534, 4, "after_rst");

        // DUT B: 8-byte bus, read latency 3, fetch wraps past the top of the address space
        bus_b.if_addr = 32'hFFFF_FFFC; bus_b.if_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus_b.if_done && n < 40);
        chk("b_if_lat", 64'(n - 1), 64'd12);
        chk("b_if_rdata", bus_b.if_rdata, 64'h0807_0605_0403_8201);
        chk("b_mem_a_wrap", 64'(bus_b.mem_a), 64'h3);
        bus_b.if_req = 1'b0;
        tick();
        bus_b.dm_we = 1'b0; bus_b.dm_size = 2'd0; bus_b.dm_signed = 1'b1;
        bus_b.dm_addr = 32'h3FD; bus_b.dm_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus_b.dm_done && n < 40);
        chk("b_ld_byte_lat", 64'(n - 1), 64'd5);
        chk("b_ld_byte_s", bus_b.dm_rdata, 64'hFFFF_FFFF_FFFF_FF82);
        bus_b.dm_req = 1'b0;
        tick();
        bus_b.dm_size = 2'd3; bus_b.dm_signed = 1'b0; bus_b.dm_addr = 32'h0;
        bus_b.dm_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus_b.dm_done && n < 40);
        chk("b_ld_dword_lat", 64'(n - 1), 64'd12);
        chk("b_ld_dword", bus_b.dm_rdata, 64'h0000_0000_0807_0605);
        bus_b.dm_req = 1'b0;
        tick(); tick();

        chk("dm_q_drained", 64'(dm_q.size()), 64'd0);
        chk("if_q_drained", 64'(if_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
